// File: rtl/endec_job_scheduler.sv
// Round-robin job scheduler that time-shares one endec encoder/Viterbi core between an
// encode requester and a decode requester, returning tagged results on a valid/ready port.
module endec_job_scheduler #(
    parameter int GP_W        = 24,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              i_enc_valid,
    output logic              o_enc_ready,
    input  logic [127:0]      i_enc_frame,
    input  logic              i_enc_code_rate,
    input  logic              i_enc_constr_len,
    input  logic [GP_W-1:0]   i_enc_gen_poly,
    input  logic              i_dec_valid,
    output logic              o_dec_ready,
    input  logic [383:0]      i_dec_frame,
    input  logic              i_dec_code_rate,
    input  logic              i_dec_constr_len,
    input  logic [GP_W-1:0]   i_dec_gen_poly,
    output logic              o_core_en,
    output logic              o_core_mode_sel,
    output logic              o_core_code_rate,
    output logic              o_core_constr_len,
    output logic [GP_W-1:0]   o_core_gen_poly,
    output logic [127:0]      o_core_enc_frame,
    output logic [383:0]      o_core_dec_frame,
    input  logic [383:0]      i_core_enc_data,
    input  logic              i_core_enc_done,
    input  logic [127:0]      i_core_dec_data,
    input  logic              i_core_dec_done,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_res_mode,
    output logic [383:0]      o_res_data,
    output logic              o_res_err,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_RUN     = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              grant_enc_s;
    logic              grant_dec_s;
    logic              done_s;
    logic              timeout_s;

    logic              enc_pref_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              core_en_r;
    logic              mode_r;
    logic              code_rate_r;
    logic              constr_len_r;
    logic [GP_W-1:0]   gen_poly_r;
    logic [127:0]      enc_frame_r;
    logic [383:0]      dec_frame_r;
    logic              res_valid_r;
    logic              res_mode_r;
    logic [383:0]      res_data_r;
    logic              res_err_r;
    logic              busy_r;

    // Next-state, arbitration and completion decode
    always_comb begin
        state_nxt_s = state_r;
        grant_enc_s = 1'b0;
        grant_dec_s = 1'b0;
        done_s      = mode_r ? i_core_dec_done : i_core_enc_done;
        timeout_s   = (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
        case (state_r)
            S_IDLE: begin
                if (rst) begin
                    state_nxt_s = S_IDLE;
                end else if (i_enc_valid && (!i_dec_valid || enc_pref_r)) begin
                    grant_enc_s = 1'b1;
                    state_nxt_s = S_SETUP;
                end else if (i_dec_valid) begin
                    grant_dec_s = 1'b1;
                    state_nxt_s = S_SETUP;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SETUP: begin
                state_nxt_s = S_RUN;
            end
            S_RUN: begin
                if (done_s || timeout_s) begin
                    state_nxt_s = S_DELIVER;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DELIVER: begin
                if (i_res_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DELIVER;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Job latch, core drive, timeout counter and result capture
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            enc_pref_r   <= 1'b1;
            to_cnt_r     <= {TO_W{1'b0}};
            core_en_r    <= 1'b0;
            mode_r       <= 1'b0;
            code_rate_r  <= 1'b0;
            constr_len_r <= 1'b0;
            gen_poly_r   <= {GP_W{1'b0}};
            enc_frame_r  <= 128'd0;
            dec_frame_r  <= 384'd0;
            res_valid_r  <= 1'b0;
            res_mode_r   <= 1'b0;
            res_data_r   <= 384'd0;
            res_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            // Output strobes follow the state we are entering, so they line up with it.
            core_en_r   <= (state_nxt_s == S_RUN);
            res_valid_r <= (state_nxt_s == S_DELIVER);
            busy_r      <= (state_nxt_s != S_IDLE);

            if (grant_enc_s || grant_dec_s) begin
                enc_pref_r   <= grant_dec_s;
                mode_r       <= grant_dec_s;
                code_rate_r  <= grant_dec_s ? i_dec_code_rate  : i_enc_code_rate;
                constr_len_r <= grant_dec_s ? i_dec_constr_len : i_enc_constr_len;
                gen_poly_r   <= grant_dec_s ? i_dec_gen_poly   : i_enc_gen_poly;
                enc_frame_r  <= grant_enc_s ? i_enc_frame : 128'd0;
                dec_frame_r  <= grant_dec_s ? i_dec_frame : 384'd0;
            end

            if (state_r == S_SETUP) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (state_r == S_RUN) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end

            // Done takes priority over a coincident timeout.
            if ((state_r == S_RUN) && (done_s || timeout_s)) begin
                res_mode_r <= mode_r;
                res_err_r  <= !done_s;
                if (!done_s) begin
                    res_data_r <= 384'd0;
                end else if (mode_r) begin
                    res_data_r <= {256'd0, i_core_dec_data};
                end else begin
                    res_data_r <= i_core_enc_data;
                end
            end
        end
    end

    assign o_enc_ready       = grant_enc_s;
    assign o_dec_ready       = grant_dec_s;
    assign o_core_en         = core_en_r;
    assign o_core_mode_sel   = mode_r;
    assign o_core_code_rate  = code_rate_r;
    assign o_core_constr_len = constr_len_r;
    assign o_core_gen_poly   = gen_poly_r;
    assign o_core_enc_frame  = enc_frame_r;
    assign o_core_dec_frame  = dec_frame_r;
    assign o_res_valid       = res_valid_r;
    assign o_res_mode        = res_mode_r;
    assign o_res_data        = res_data_r;
    assign o_res_err         = res_err_r;
    assign o_busy            = busy_r;

endmodule

// File: tb/tb_endec_job_scheduler.sv
// Directed bench for endec_job_scheduler: the core is modelled by driving done/data at
// hand-chosen cycles, and every result is compared against hand-computed values.
module tb_endec_job_scheduler;

    localparam int GP_W = 24;
    localparam int TCYC = 16;
    localparam int TO_W = 5;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              i_enc_valid;
    logic              o_enc_ready;
    logic [127:0]      i_enc_frame;
    logic              i_enc_code_rate;
    logic              i_enc_constr_len;
    logic [GP_W-1:0]   i_enc_gen_poly;
    logic              i_dec_valid;
    logic              o_dec_ready;
    logic [383:0]      i_dec_frame;
    logic              i_dec_code_rate;
    logic              i_dec_constr_len;
    logic [GP_W-1:0]   i_dec_gen_poly;
    logic              o_core_en;
    logic              o_core_mode_sel;
    logic              o_core_code_rate;
    logic              o_core_constr_len;
    logic [GP_W-1:0]   o_core_gen_poly;
    logic [127:0]      o_core_enc_frame;
    logic [383:0]      o_core_dec_frame;
    logic [383:0]      i_core_enc_data;
    logic              i_core_enc_done;
    logic [127:0]      i_core_dec_data;
    logic              i_core_dec_done;
    logic              o_res_valid;
    logic              i_res_ready;
    logic              o_res_mode;
    logic [383:0]      o_res_data;
    logic              o_res_err;
    logic              o_busy;

    int n_vec = 0;
    int n_err = 0;

    endec_job_scheduler #(.GP_W(GP_W), .TIMEOUT_CYC(TCYC), .TO_W(TO_W)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .i_enc_valid(i_enc_valid), .o_enc_ready(o_enc_ready), .i_enc_frame(i_enc_frame),
        .i_enc_code_rate(i_enc_code_rate), .i_enc_constr_len(i_enc_constr_len),
        .i_enc_gen_poly(i_enc_gen_poly),
        .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready), .i_dec_frame(i_dec_frame),
        .i_dec_code_rate(i_dec_code_rate), .i_dec_constr_len(i_dec_constr_len),
        .i_dec_gen_poly(i_dec_gen_poly),
        .o_core_en(o_core_en), .o_core_mode_sel(o_core_mode_sel),
        .o_core_code_rate(o_core_code_rate), .o_core_constr_len(o_core_constr_len),
        .o_core_gen_poly(o_core_gen_poly), .o_core_enc_frame(o_core_enc_frame),
        .o_core_dec_frame(o_core_dec_frame),
        .i_core_enc_data(i_core_enc_data), .i_core_enc_done(i_core_enc_done),
        .i_core_dec_data(i_core_dec_data), .i_core_dec_done(i_core_dec_done),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_mode(o_res_mode),
        .o_res_data(o_res_data), .o_res_err(o_res_err), .o_busy(o_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    // Called in the SETUP cycle: runs the job with done at en-rise + lat, holds the
    // result for 'hold' cycles of backpressure, then hands it off.
    task automatic finish_job(input bit is_dec, input int lat, input logic [383:0] core_data,
                              input logic [383:0] exp, input int hold);
        logic [383:0] held;
        check("setup_en", 384'(o_core_en), 384'd0);
        check("setup_busy", 384'(o_busy), 384'd1);
        tick();
        check("en_rise", 384'(o_core_en), 384'd1);
        i_core_enc_done = is_dec;
        i_core_dec_done = !is_dec;
        for (int k = 0; k < lat; k++) begin
            tick();
            check("run_en", 384'(o_core_en), 384'd1);
            check("run_noval", 384'(o_res_valid), 384'd0);
            check("run_rdy", 384'({o_enc_ready, o_dec_ready}), 384'd0);
        end
        if (is_dec) begin
            i_core_enc_done = 1'b0;
            i_core_dec_done = 1'b1;
            i_core_dec_data = core_data[127:0];
            i_core_enc_data = {384{1'b1}};
        end else begin
            i_core_dec_done = 1'b0;
            i_core_enc_done = 1'b1;
            i_core_enc_data = core_data;
            i_core_dec_data = {128{1'b1}};
        end
        tick();
        i_core_enc_done = 1'b0;
        i_core_dec_done = 1'b0;
        i_core_enc_data = 384'd0;
        i_core_dec_data = 128'd0;
        check("res_valid", 384'(o_res_valid), 384'd1);
        check("res_mode", 384'(o_res_mode), 384'(is_dec));
        check("res_data", o_res_data, exp);
        check("res_err", 384'(o_res_err), 384'd0);
        check("deliver_en", 384'(o_core_en), 384'd0);
        held = o_res_data;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_valid", 384'(o_res_valid), 384'd1);
            check("hold_data", o_res_data, held);
            check("hold_rdy", 384'({o_enc_ready, o_dec_ready}), 384'd0);
        end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        check("post_valid", 384'(o_res_valid), 384'd0);
        check("post_busy", 384'(o_busy), 384'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_enc_valid = 1'b1; i_enc_frame = 128'd0; i_enc_code_rate = 1'b0;
        i_enc_constr_len = 1'b0; i_enc_gen_poly = 24'd0;
        i_dec_valid = 1'b1; i_dec_frame = 384'd0; i_dec_code_rate = 1'b0;
        i_dec_constr_len = 1'b0; i_dec_gen_poly = 24'd0;
        i_core_enc_data = 384'd0; i_core_enc_done = 1'b0;
        i_core_dec_data = 128'd0; i_core_dec_done = 1'b0;
        i_res_ready = 1'b0;

        // Reset state, with both requests pending
        repeat (2) tick();
        check("rst_busy", 384'(o_busy), 384'd0);
        check("rst_en", 384'(o_core_en), 384'd0);
        check("rst_valid", 384'(o_res_valid), 384'd0);
        check("rst_rdy", 384'({o_enc_ready, o_dec_ready}), 384'd0);
        check("rst_gp", 384'(o_core_gen_poly), 384'd0);
        i_enc_valid = 1'b0;
        i_dec_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single encode job
        i_enc_valid = 1'b1; i_enc_frame = 128'h1; i_enc_code_rate = 1'b1;
        i_enc_constr_len = 1'b0; i_enc_gen_poly = 24'hABCDEF;
        #1;
        check("t1_rdy", 384'({o_enc_ready, o_dec_ready}), 384'd2);
        tick();
        i_enc_valid = 1'b0; i_enc_frame = 128'hDEAD; i_enc_gen_poly = 24'h111111;
        check("t1_mode", 384'(o_core_mode_sel), 384'd0);
        check("t1_rate", 384'(o_core_code_rate), 384'd1);
        check("t1_constr", 384'(o_core_constr_len), 384'd0);
        check("t1_gp", 384'(o_core_gen_poly), 384'hABCDEF);
        check("t1_efr", 384'(o_core_enc_frame), 384'h1);
        check("t1_dfr", o_core_dec_frame, 384'd0);
        finish_job(1'b0, 10, 384'h5, 384'h5, 0);

        // Arbitration: both valid every cycle from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            i_enc_valid = 1'b1; i_dec_valid = 1'b1;
            i_enc_frame = 128'(16'hA0 + j);
            i_dec_frame = 384'(16'hB0 + j);
            #1;
            check("arb_enc_rdy", 384'(o_enc_ready), 384'(j % 2 == 0));
            check("arb_dec_rdy", 384'(o_dec_ready), 384'(j % 2 == 1));
            tick();
            check("arb_mode", 384'(o_core_mode_sel), 384'(j % 2));
            if (j % 2 == 0) begin
                check("arb_efr", 384'(o_core_enc_frame), 384'(16'hA0 + j));
                check("arb_dfr", o_core_dec_frame, 384'd0);
            end else begin
                check("arb_efr", 384'(o_core_enc_frame), 384'd0);
                check("arb_dfr", o_core_dec_frame, 384'(16'hB0 + j));
            end
            finish_job(j % 2 == 1, 3, 384'(16'hC0 + j), 384'(16'hC0 + j), 0);
        end
        i_enc_valid = 1'b0; i_dec_valid = 1'b0;

        // Decode job, stray enc_done ignored, zero-extended result
        i_dec_valid = 1'b1; i_dec_frame = {128'h3, 128'h2, 128'h1}; i_dec_code_rate = 1'b0;
        i_dec_constr_len = 1'b1; i_dec_gen_poly = 24'h123456;
        #1;
        check("t3_rdy", 384'({o_enc_ready, o_dec_ready}), 384'd1);
        tick();
        i_dec_valid = 1'b0; i_dec_frame = 384'd0;
        check("t3_mode", 384'(o_core_mode_sel), 384'd1);
        check("t3_rate", 384'(o_core_code_rate), 384'd0);
        check("t3_constr", 384'(o_core_constr_len), 384'd1);
        check("t3_gp", 384'(o_core_gen_poly), 384'h123456);
        check("t3_dfr", o_core_dec_frame, {128'h3, 128'h2, 128'h1});
        check("t3_efr", 384'(o_core_enc_frame), 384'd0);
        finish_job(1'b1, 5, 384'hFFFF, {256'h0, 128'hFFFF}, 0);

        // Timeout: no done for TCYC run cycles
        i_enc_valid = 1'b1;
        #1;
        check("t4_rdy", 384'(o_enc_ready), 384'd1);
        tick();
        i_enc_valid = 1'b0;
        tick();
        check("t4_en", 384'(o_core_en), 384'd1);
        i_core_enc_data = {384{1'b1}};
        for (int k = 1; k < TCYC; k++) begin
            tick();
            check("t4_run", 384'({o_core_en, o_res_valid}), 384'd2);
        end
        tick();
        check("t4_valid", 384'(o_res_valid), 384'd1);
        check("t4_err", 384'(o_res_err), 384'd1);
        check("t4_data", o_res_data, 384'd0);
        check("t4_mode", 384'(o_res_mode), 384'd0);
        check("t4_en_off", 384'(o_core_en), 384'd0);
        i_core_enc_data = 384'd0;
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        check("t4_post", 384'(o_res_valid), 384'd0);

        // Backpressure with both requests pending
        i_enc_valid = 1'b1; i_enc_frame = 128'h77;
        #1;
        check("t5_rdy", 384'(o_enc_ready), 384'd1);
        tick();
        i_dec_valid = 1'b1;
        finish_job(1'b0, 2, 384'h9A9A, 384'h9A9A, 20);
        #1;
        check("t5_next_rdy", 384'({o_enc_ready, o_dec_ready}), 384'd1);
        tick();
        i_enc_valid = 1'b0; i_dec_valid = 1'b0;
        check("t5_next_mode", 384'(o_core_mode_sel), 384'd1);
        finish_job(1'b1, 2, 384'h42, 384'h42, 0);

        // Reset mid-RUN, then encode preferred again
        i_enc_valid = 1'b1;
        tick();
        i_enc_valid = 1'b0;
        repeat (2) tick();
        check("t6_run_en", 384'(o_core_en), 384'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_en", 384'(o_core_en), 384'd0);
        check("t6_busy", 384'(o_busy), 384'd0);
        check("t6_valid", 384'(o_res_valid), 384'd0);
        i_enc_valid = 1'b1; i_dec_valid = 1'b1; i_enc_frame = 128'h5A;
        #1;
        check("t6_rdy", 384'({o_enc_ready, o_dec_ready}), 384'd2);
        tick();
        i_enc_valid = 1'b0; i_dec_valid = 1'b0;
        check("t6_mode", 384'(o_core_mode_sel), 384'd0);
        check("t6_efr", 384'(o_core_enc_frame), 384'h5A);
        finish_job(1'b0, 4, 384'h3C, 384'h3C, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
